// File: rtl/encoder_event_gen_if.sv
// Event handshake between encoder_event_gen (master) and the downstream event FIFO (slave).
interface encoder_event_gen_if;
    logic [7:0] evCode;
    logic       evValid;
    logic       evReady;

    modport master (output evCode, output evValid, input evReady);
    modport slave  (input evCode, input evValid, output evReady);
endinterface

// File: rtl/encoder_event_gen.sv
// Four rotary encoders + push keys: sync, debounce, quadrature/edge decode, round-robin serialise to 8-bit events.
// Optional macro ENCODER_ACCEL_EN adds per-encoder interval timers that drive the "fast" code bit.
module encoder_event_gen #(
    parameter int DEB_LEN = 4,
    parameter int STEP_W  = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          encA,
    input  logic [3:0]          encB,
    input  logic [3:0]          encKey,
    input  logic                clrOvf,
    output logic                overflow,
    encoder_event_gen_if.master ev
);
    localparam logic [0:0]        ST_IDLE    = 1'b0;
    localparam logic [0:0]        ST_OFFER   = 1'b1;
    localparam int                STEP_LIM   = (1 << (STEP_W - 1)) - 1;
    localparam logic signed [3:0] SUB_MAX    = 4'sb0111;
    localparam logic signed [3:0] SUB_MIN    = 4'sb1000;
    localparam logic signed [3:0] DETENT_CW  = 4'sb0100;
    localparam logic signed [3:0] DETENT_CCW = 4'sb1100;

    // Line map: [3:0] A, [7:4] B, [11:8] keys
    logic [11:0]      raw, sync1, sync2, deb, deb_d;
    logic [11:0][3:0] deb_cnt;

    assign raw = {encKey, encB, encA};

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1   <= '1;
            sync2   <= '1;
            deb     <= '1;
            deb_d   <= '1;
            deb_cnt <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_d <= deb;
            for (int i = 0; i < 12; i++) begin
                if (sync2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == 4'(DEB_LEN - 1)) begin
                    deb[i]     <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 4'd1;
                end
            end
        end
    end

    function automatic logic [1:0] gray_pos(input logic [1:0] ab);
        case (ab)
            2'b11:   return 2'd0;
            2'b10:   return 2'd1;
            2'b00:   return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    logic signed [3:0]        sub_cnt [4];
    logic signed [3:0]        sub_nxt [4];
    logic [3:0]               enter_det, step_cw, step_ccw;

    always_comb begin
        enter_det = '0;
        step_cw   = '0;
        step_ccw  = '0;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] cur, prv;
            cur        = {deb[i], deb[4+i]};
            prv        = {deb_d[i], deb_d[4+i]};
            sub_nxt[i] = sub_cnt[i];
            // A simultaneous change of both lines carries no direction and is ignored
            if (cur != prv && (cur ^ prv) != 2'b11) begin
                if (gray_pos(cur) == 2'(gray_pos(prv) + 2'd1)) begin
                    if (sub_cnt[i] != SUB_MAX) sub_nxt[i] = sub_cnt[i] + 4'sd1;
                end else if (sub_cnt[i] != SUB_MIN) begin
                    sub_nxt[i] = sub_cnt[i] - 4'sd1;
                end
            end
            enter_det[i] = (cur == 2'b11) && (prv != 2'b11);
            step_cw[i]   = enter_det[i] && (sub_nxt[i] == DETENT_CW);
            step_ccw[i]  = enter_det[i] && (sub_nxt[i] == DETENT_CCW);
        end
    end

    logic [0:0]               state;
    logic [2:0]               last_gnt;
    logic                     xfer;
    logic [3:0]               press_pend, rel_pend, press_nxt, rel_nxt;
    logic [3:0]               key_fall, key_rise, clr_press, clr_rel, xfer_enc, ovf_enc;
    logic                     ovf_key, ovf_any;
    logic signed [STEP_W-1:0] step_cnt [4];
    logic signed [STEP_W-1:0] cnt_nxt  [4];

    // In OFFER, last_gnt is the source being offered and evCode[5:4] its event type
    assign xfer      = (state == ST_OFFER) && ev.evReady;
    assign clr_press = (xfer && !last_gnt[2] && ev.evCode[5:4] == 2'b00) ? (4'b0001 << last_gnt[1:0]) : 4'b0000;
    assign clr_rel   = (xfer && !last_gnt[2] && ev.evCode[5:4] == 2'b01) ? (4'b0001 << last_gnt[1:0]) : 4'b0000;
    assign xfer_enc  = (xfer && last_gnt[2]) ? (4'b0001 << last_gnt[1:0]) : 4'b0000;
    assign key_fall  = deb_d[11:8] & ~deb[11:8];
    assign key_rise  = ~deb_d[11:8] & deb[11:8];
    assign press_nxt = (press_pend & ~clr_press) | key_fall;
    assign rel_nxt   = (rel_pend & ~clr_rel) | key_rise;
    assign ovf_key   = |(key_fall & press_pend & ~clr_press) | |(key_rise & rel_pend & ~clr_rel);
    assign ovf_any   = ovf_key | (|ovf_enc);

    // Transfer moves toward zero first, so a same-direction step in the same cycle nets out
    always_comb begin
        ovf_enc = '0;
        for (int i = 0; i < 4; i++) begin
            int t;
            t = int'(step_cnt[i]);
            if (xfer_enc[i]) t = (t > 0) ? t - 1 : t + 1;
            if (step_cw[i]) begin
                if (t == STEP_LIM) ovf_enc[i] = 1'b1;
                else               t = t + 1;
            end else if (step_ccw[i]) begin
                if (t == -STEP_LIM) ovf_enc[i] = 1'b1;
                else                t = t - 1;
            end
            cnt_nxt[i] = STEP_W'(t);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            press_pend <= '0;
            rel_pend   <= '0;
            overflow   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                step_cnt[i] <= '0;
                sub_cnt[i]  <= '0;
            end
        end else begin
            press_pend <= press_nxt;
            rel_pend   <= rel_nxt;
            for (int i = 0; i < 4; i++) begin
                step_cnt[i] <= cnt_nxt[i];
                sub_cnt[i]  <= enter_det[i] ? 4'sd0 : sub_nxt[i];
            end
            if (ovf_any)     overflow <= 1'b1;
            else if (clrOvf) overflow <= 1'b0;
        end
    end

    logic [7:0] src_rdy;
    logic       found;
    logic [2:0] sel;
    logic [1:0] sel_type;
    logic       sel_fast;

    // A pending release waits behind its press on the same key
    always_comb begin
        src_rdy[3:0] = press_pend | rel_pend;
        for (int i = 0; i < 4; i++) src_rdy[4+i] = (step_cnt[i] != '0);
        found = 1'b0;
        sel   = last_gnt;
        for (int k = 1; k <= 8; k++) begin
            if (!found && src_rdy[3'(int'(last_gnt) + k)]) begin
                found = 1'b1;
                sel   = 3'(int'(last_gnt) + k);
            end
        end
        if (!sel[2]) sel_type = press_pend[sel[1:0]] ? 2'b00 : 2'b01;
        else         sel_type = step_cnt[sel[1:0]][STEP_W-1] ? 2'b11 : 2'b10;
    end

`ifdef ENCODER_ACCEL_EN
    logic [3:0][11:0] ivl;
    logic [3:0]       last_cw;

    // Timers start saturated so the first step after reset is never fast
    always_ff @(posedge clk) begin
        if (!rst) begin
            ivl     <= '1;
            last_cw <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (state == ST_IDLE && found && sel == 3'(i + 4)) begin
                    ivl[i]     <= '0;
                    last_cw[i] <= (sel_type == 2'b10);
                end else if (ivl[i] != 12'hFFF) begin
                    ivl[i] <= ivl[i] + 12'd1;
                end
            end
        end
    end

    assign sel_fast = sel[2] && (ivl[sel[1:0]] < 12'd1024) && (last_cw[sel[1:0]] == (sel_type == 2'b10));
`else
    assign sel_fast = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            last_gnt   <= 3'd7;
            ev.evValid <= 1'b0;
            ev.evCode  <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        ev.evCode  <= {2'b11, sel_type, 1'b0, sel_fast, sel[1:0]};
                        ev.evValid <= 1'b1;
                        last_gnt   <= sel;
                        state      <= ST_OFFER;
                    end
                end
                default: begin
                    if (ev.evReady) begin
                        ev.evValid <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_encoder_event_gen.sv
// Scoreboard bench for encoder_event_gen: expected codes are queued as stimulus is driven and popped on each transfer.
`timescale 1ns/1ps
module tb_encoder_event_gen;
    localparam int DEB_LEN = 4;
`ifdef ENCODER_ACCEL_EN
    localparam logic ACCEL = 1'b1;
`else
    localparam logic ACCEL = 1'b0;
`endif
    localparam logic [1:0] T_PRESS = 2'b00;
    localparam logic [1:0] T_REL   = 2'b01;
    localparam logic [1:0] T_CW    = 2'b10;
    localparam logic [1:0] T_CCW   = 2'b11;

    logic       clk    = 1'b0;
    logic       rst    = 1'b0;
    logic [3:0] encA   = 4'hF;
    logic [3:0] encB   = 4'hF;
    logic [3:0] encKey = 4'hF;
    logic       clrOvf = 1'b0;
    logic       overflow;

    int         n_tests      = 0;
    int         n_fail       = 0;
    int         valid_cycles = 0;
    logic [7:0] exp_q [$];

    encoder_event_gen_if ev_if ();

    encoder_event_gen #(.DEB_LEN(DEB_LEN), .STEP_W(3)) dut (
        .clk(clk), .rst(rst), .encA(encA), .encB(encB), .encKey(encKey),
        .clrOvf(clrOvf), .overflow(overflow), .ev(ev_if)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] make_code(input logic [1:0] typ, input logic fast, input logic [1:0] idx);
        return {2'b11, typ, 1'b0, fast, idx};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(1);
    endtask

    task automatic enc_step(input int idx, input logic cw, input int dwell);
        logic [1:0] seq [4];
        if (cw) seq = '{2'b10, 2'b00, 2'b01, 2'b11};
        else    seq = '{2'b01, 2'b00, 2'b10, 2'b11};
        for (int s = 0; s < 4; s++) begin
            encA[idx] = seq[s][1];
            encB[idx] = seq[s][0];
            tick(dwell);
        end
    endtask

    task automatic drain(input int budget, output logic ok);
        for (int c = 0; c < budget && exp_q.size() != 0; c++) tick(1);
        ok = (exp_q.size() == 0);
        if (!ok) exp_q.delete();
        tick(2);
    endtask

    task automatic run_monitor();
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rst && ev_if.evValid) valid_cycles++;
            if (rst && ev_if.evValid && ev_if.evReady) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: got %h, no event expected", ev_if.evCode);
                end else begin
                    e = exp_q.pop_front();
                    if (ev_if.evCode !== e) begin
                        n_fail++;
                        $display("FAIL sb_code: got %h, expected %h", ev_if.evCode, e);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            n_tests++;
            if (ev_if.evValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, expected 0", ev_if.evValid); end
            n_tests++;
            if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b, expected 0", overflow); end
            n_tests++;
            if (ev_if.evCode !== 8'h00) begin n_fail++; $display("FAIL reset_code: got %h, expected 00", ev_if.evCode); end
        end
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_latency();
        logic seen;
        logic ok;
        int   n;
        ev_if.evReady = 1'b1;
        exp_q.push_back(make_code(T_PRESS, 1'b0, 2'd2));
        encKey[2] = 1'b0;
        seen = 1'b0;
        n    = 0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (ev_if.evValid) begin seen = 1'b1; n = c; end
        end
        n_tests++;
        if (!seen || n != DEB_LEN + 4) begin
            n_fail++;
            $display("FAIL latency: got %0d cycles (seen=%b), expected %0d", n, seen, DEB_LEN + 4);
        end
        tick(5);
        exp_q.push_back(make_code(T_REL, 1'b0, 2'd2));
        encKey[2] = 1'b1;
        drain(100, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL latency_drain: events outstanding, expected none"); end
    endtask

    task automatic test_cw_step();
        int v0;
        ev_if.evReady = 1'b1;
        v0 = valid_cycles;
        exp_q.push_back(make_code(T_CW, 1'b0, 2'd2));
        enc_step(2, 1'b1, 20);
        tick(30);
        n_tests++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL cw_drain: %0d outstanding, expected 0", exp_q.size()); exp_q.delete(); end
        n_tests++;
        if (valid_cycles - v0 != 1) begin n_fail++; $display("FAIL cw_valid_len: got %0d, expected 1", valid_cycles - v0); end
    endtask

    task automatic test_ccw_saturate();
        logic ok;
        int   v0;
        ev_if.evReady = 1'b0;
        repeat (3) exp_q.push_back(make_code(T_CCW, 1'b0, 2'd0));
        repeat (5) enc_step(0, 1'b0, 10);
        tick(20);
        @(negedge clk);
        n_tests++;
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL sat_ovf: got %b, expected 1", overflow); end
        n_tests++;
        if (ev_if.evValid !== 1'b1 || ev_if.evCode !== make_code(T_CCW, 1'b0, 2'd0)) begin
            n_fail++;
            $display("FAIL sat_offer: got v=%b code=%h, expected v=1 code=%h", ev_if.evValid, ev_if.evCode, make_code(T_CCW, 1'b0, 2'd0));
        end
        @(posedge clk);
        #1 ev_if.evReady = 1'b1;
        drain(200, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL sat_drain: events outstanding, expected none"); end
        v0 = valid_cycles;
        tick(40);
        n_tests++;
        if (valid_cycles != v0) begin n_fail++; $display("FAIL sat_extra: got %0d extra valid cycles, expected 0", valid_cycles - v0); end
        n_tests++;
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b, expected 1", overflow); end
        clrOvf = 1'b1;
        tick(1);
        clrOvf = 1'b0;
        @(negedge clk);
        n_tests++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b, expected 0", overflow); end
    endtask

    task automatic test_key_order();
        logic ok;
        @(posedge clk);
        #1 ev_if.evReady = 1'b0;
        exp_q.push_back(make_code(T_PRESS, 1'b0, 2'd1));
        encKey[1] = 1'b0;
        tick(50);
        exp_q.push_back(make_code(T_REL, 1'b0, 2'd1));
        encKey[1] = 1'b1;
        tick(50);
        @(negedge clk);
        n_tests++;
        if (ev_if.evValid !== 1'b1 || ev_if.evCode !== make_code(T_PRESS, 1'b0, 2'd1)) begin
            n_fail++;
            $display("FAIL key_press_first: got v=%b code=%h, expected v=1 code=%h", ev_if.evValid, ev_if.evCode, make_code(T_PRESS, 1'b0, 2'd1));
        end
        @(posedge clk);
        #1 ev_if.evReady = 1'b1;
        drain(100, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL key_drain: events outstanding, expected none"); end
        do_reset();
        exp_q.push_back(make_code(T_PRESS, 1'b0, 2'd0));
        exp_q.push_back(make_code(T_PRESS, 1'b0, 2'd3));
        encKey = 4'b0110;
        tick(30);
        exp_q.push_back(make_code(T_REL, 1'b0, 2'd0));
        exp_q.push_back(make_code(T_REL, 1'b0, 2'd3));
        encKey = 4'hF;
        drain(100, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL key_rr_drain: events outstanding, expected none"); end
    endtask

    task automatic test_glitch();
        int v0;
        ev_if.evReady = 1'b1;
        v0 = valid_cycles;
        encA[1] = 1'b0;
        tick(3);
        encA[1] = 1'b1;
        tick(30);
        n_tests++;
        if (valid_cycles != v0) begin n_fail++; $display("FAIL glitch: got %0d valid cycles, expected 0", valid_cycles - v0); end
    endtask

    task automatic test_offer_hold();
        logic seen;
        logic ok;
        ev_if.evReady = 1'b0;
        exp_q.push_back(make_code(T_PRESS, 1'b0, 2'd3));
        encKey[3] = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (ev_if.evValid) seen = 1'b1;
        end
        n_tests++;
        if (!seen) begin n_fail++; $display("FAIL offer_timeout: evValid=0 after 40 cycles, expected 1"); end
        repeat (10) begin
            @(negedge clk);
            n_tests++;
            if (ev_if.evValid !== 1'b1 || ev_if.evCode !== make_code(T_PRESS, 1'b0, 2'd3)) begin
                n_fail++;
                $display("FAIL offer_hold: got v=%b code=%h, expected v=1 code=%h", ev_if.evValid, ev_if.evCode, make_code(T_PRESS, 1'b0, 2'd3));
            end
        end
        @(posedge clk);
        #1 ev_if.evReady = 1'b1;
        exp_q.push_back(make_code(T_REL, 1'b0, 2'd3));
        encKey[3] = 1'b1;
        drain(100, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL offer_drain: events outstanding, expected none"); end
    endtask

    task automatic test_accel();
        logic ok;
        do_reset();
        ev_if.evReady = 1'b1;
        exp_q.push_back(make_code(T_CW, 1'b0, 2'd3));
        enc_step(3, 1'b1, 20);
        tick(420);
        exp_q.push_back(make_code(T_CW, ACCEL, 2'd3));
        enc_step(3, 1'b1, 20);
        drain(200, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL accel_drain: events outstanding, expected none"); end
    endtask

    initial begin
        ev_if.evReady = 1'b0;
        fork
            run_monitor();
        join_none
        test_reset();
        test_latency();
        test_cw_step();
        test_ccw_saturate();
        test_key_order();
        test_glitch();
        test_offer_hold();
        test_accel();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
